// File: rtl/phase0_pkg.sv
// Shared types for the phase0 table loader: FSM state encoding and error codes.
package phase0_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } phase0_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_LONG    = 2'd3;

endpackage

// File: rtl/phase0_table_loader_if.sv
// Valid/ready word stream feeding the phase0 table loader; the host drives master, the loader is slave.
interface phase0_table_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/phase0_checksum_acc.sv
// Wrapping accumulator of loaded table words; cleared when a new load is accepted.
module phase0_checksum_acc #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/phase0_table_loader.sv
// Runtime writer for the phase0 lookup BRAM: start command + word stream -> registered single-word writes.
// Define PHASE0_LOADER_CHECKSUM_EN to build the running checksum of loaded words; otherwise checksum is 0.
module phase0_table_loader
  import phase0_pkg::*;
#(
  parameter int CLASSIFIER_ID = 0,
  parameter int PHASE0_INDEX  = 0,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 65536
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_base,
  input  logic [ADDR_WIDTH:0]   start_len,
  phase0_table_loader_if.slave  s,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dinb,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // The identity parameters only tag the instance; reject nonsense values at elaboration.
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH) ||
      CLASSIFIER_ID < 0 || PHASE0_INDEX < 0) begin : g_bad_params
    $error("phase0_table_loader: illegal parameter set");
  end

  phase0_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH:0]   last_idx_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic [ADDR_WIDTH+1:0] cmd_end;
  logic                  cmd_ok;
  logic                  cmd_take;
  logic                  hs;
  logic                  at_last;
  logic [1:0]            err_nxt;

  // Range check is two bits wider than the address so base+len==DEPTH cannot overflow.
  assign cmd_end = {2'b00, start_base} + {1'b0, start_len};
  assign cmd_ok  = (start_len != '0) && (cmd_end <= DEPTH_X);
  assign hs      = (state == LOAD) && s.valid;
  assign at_last = (cnt_r == last_idx_r);

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    cmd_take  = 1'b0;
    s.ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (cmd_ok) begin
            cmd_take  = 1'b1;
            err_nxt   = ERR_NONE;
            state_nxt = LOAD;
          end else begin
            err_nxt = ERR_BAD_CMD;
          end
        end
      end
      LOAD: begin
        s.ready = 1'b1;
        if (hs) begin
          if (at_last && s.last) begin
            state_nxt = DONE;
          end else if (s.last) begin
            err_nxt   = ERR_SHORT;
            state_nxt = IDLE;
          end else if (at_last) begin
            err_nxt   = ERR_LONG;
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write port stage: one registered write the cycle after each accepted word.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      err_code   <= ERR_NONE;
      base_r     <= '0;
      last_idx_r <= '0;
      cnt_r      <= '0;
      web        <= 1'b0;
      addrb      <= '0;
      dinb       <= '0;
    end else begin
      err_code <= err_nxt;
      web      <= hs;
      if (cmd_take) begin
        base_r     <= start_base;
        last_idx_r <= start_len - CNT_ONE;
        cnt_r      <= '0;
      end
      if (hs) begin
        addrb <= base_r + cnt_r[ADDR_WIDTH-1:0];
        dinb  <= s.data;
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

`ifdef PHASE0_LOADER_CHECKSUM_EN
  phase0_checksum_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clka   (clka),
    .rsta_n (rsta_n),
    .clear  (cmd_take),
    .enable (hs),
    .data   (s.data),
    .sum    (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule
